// File: rtl/shift_sequencer.sv
// LSB-first serial shifter paced by an external interval timer.
// Optional even-parity trailer bit when SHIFT_PARITY_EN is defined.
module shift_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             tick_in,
  output logic             timer_start,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

`ifdef SHIFT_PARITY_EN
  localparam int TOTAL = WIDTH + 1;
`else
  localparam int TOTAL = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [TOTAL-1:0] shreg;
  logic [TOTAL-1:0] capture_word;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_inc;
  logic             last_bit;

  // Parity rides in the top bit so it falls out of the shifter last.
`ifdef SHIFT_PARITY_EN
  assign capture_word = {^data_in, data_in};
`else
  assign capture_word = data_in;
`endif

  always_comb begin
    bit_cnt_inc = bit_cnt + CW'(1);
    last_bit    = (bit_cnt_inc == CW'(TOTAL));
    state_n     = state;
    timer_start = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load) state_n = ARM;
      end
      ARM: begin
        timer_start = 1'b1;
        state_n     = WAIT;
      end
      WAIT: begin
        if (tick_in) state_n = SHIFT;
      end
      SHIFT: begin
        state_n = last_bit ? DONE : ARM;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      shift_en   <= 1'b0;
    end else begin
      state    <= state_n;
      shift_en <= (state == SHIFT);
      if (state == IDLE && load) begin
        shreg   <= capture_word;
        bit_cnt <= '0;
      end
      if (state == SHIFT) begin
        serial_out <= shreg[0];
        shreg      <= shreg >> 1;
        bit_cnt    <= bit_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected bits queued at load time,
// a monitor pops them on every shift_en strobe. Honours SHIFT_PARITY_EN.
module tb_shift_sequencer;

  localparam int WIDTH = 8;
`ifdef SHIFT_PARITY_EN
  localparam int TOTAL = WIDTH + 1;
`else
  localparam int TOTAL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             tick_in;
  logic             timer_start;
  logic             serial_out;
  logic             shift_en;
  logic             busy;
  logic             done;

  int compared   = 0;
  int mismatched = 0;
  int tick_delay = 11;
  bit stray_en   = 1'b0;
  int rst_epoch  = 0;
  int timer_cd   = 0;
  int mon_ts     = 0;
  int mon_sh     = 0;
  int mon_epoch  = 0;
  bit mon_prev_done = 1'b0;
  bit bit_q[$];
  int done_q[$];

  shift_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .tick_in    (tick_in),
    .timer_start(timer_start),
    .serial_out (serial_out),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Interval timer model: one tick_in pulse tick_delay cycles after timer_start,
  // plus optional stray ticks while idle or in the arming cycle.
  initial begin
    tick_in = 1'b0;
    forever begin
      @(negedge clk);
      tick_in = 1'b0;
      if (rst === 1'b1) begin
        timer_cd = 0;
      end else begin
        if (timer_cd > 0) begin
          timer_cd--;
          if (timer_cd == 0) tick_in = 1'b1;
        end
        if (timer_start === 1'b1) begin
          timer_cd = tick_delay;
          if (stray_en && $urandom_range(1, 0) == 1) tick_in = 1'b1;
        end else if (stray_en && busy === 1'b0 && $urandom_range(3, 0) == 0) begin
          tick_in = 1'b1;
        end
      end
    end
  end

  initial begin
    bit exp_bit;
    int exp_total;
    forever begin
      @(negedge clk);
      if (mon_epoch != rst_epoch) begin
        mon_epoch     = rst_epoch;
        mon_ts        = 0;
        mon_sh        = 0;
        mon_prev_done = 1'b0;
      end
      if (mon_prev_done) checkOutput("busy_after_done", busy, 0);
      if (timer_start === 1'b1) mon_ts++;
      if (shift_en === 1'b1) begin
        mon_sh++;
        if (bit_q.size() == 0) begin
          checkOutput("unexpected_shift", shift_en, 0);
        end else begin
          exp_bit = bit_q.pop_front();
          checkOutput("serial_bit", serial_out, exp_bit);
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", done, 0);
        end else begin
          exp_total = done_q.pop_front();
          checkOutput("shift_count", mon_sh, exp_total);
          checkOutput("timer_start_count", mon_ts, exp_total);
        end
        mon_sh = 0;
        mon_ts = 0;
      end
      mon_prev_done = (done === 1'b1);
    end
  end

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("done_timeout", done, 1);
  endtask

  task automatic pushExpected(input logic [WIDTH-1:0] data);
    for (int i = 0; i < WIDTH; i++) bit_q.push_back(data[i]);
`ifdef SHIFT_PARITY_EN
    bit_q.push_back(^data);
`endif
    done_q.push_back(TOTAL);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input int delay,
                               input bit ignored_load, input logic [WIDTH-1:0] ign_data);
    bit ok;
    bit last;
`ifdef SHIFT_PARITY_EN
    last = ^data;
`else
    last = data[WIDTH-1];
`endif
    tick_delay = delay;
    @(negedge clk);
    data_in = data;
    load    = 1'b1;
    pushExpected(data);
    @(negedge clk);
    load    = 1'b0;
    data_in = WIDTH'($urandom);
    checkOutput("timer_start_latency", timer_start, 1);
    checkOutput("busy_on_arm", busy, 1);
    if (ignored_load) begin
      repeat ($urandom_range(6, 1)) @(negedge clk);
      data_in = ign_data;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
    end
    waitDone(ok);
    if (ok) begin
      @(negedge clk);
      @(negedge clk);
      checkOutput("serial_hold", serial_out, last);
    end
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_serial_out"}, serial_out, 0);
    checkOutput({tag, "_shift_en"}, shift_en, 0);
    checkOutput({tag, "_timer_start"}, timer_start, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  task automatic runResetMid();
    int shifts;
    tick_delay = 6;
    @(negedge clk);
    data_in = 8'h5C;
    load    = 1'b1;
    pushExpected(8'h5C);
    @(negedge clk);
    load   = 1'b0;
    shifts = 0;
    for (int i = 0; i < 300 && shifts < 3; i++) begin
      @(negedge clk);
      if (shift_en === 1'b1) shifts++;
    end
    checkOutput("reset_pre_shifts", shifts, 3);
    @(negedge clk);
    rst = 1'b1;
    bit_q.delete();
    done_q.delete();
    rst_epoch++;
    @(negedge clk);
    rst = 1'b0;
    checkAllLow("mid_reset");
  endtask

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    checkAllLow("reset");
    rst = 1'b0;

    stray_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("idle_stray_shift_en", shift_en, 0);
      checkOutput("idle_stray_busy", busy, 0);
    end

    applyStimulus(8'hA5, 11, 1'b0, 8'h00);
    applyStimulus(8'h0F, 5, 1'b1, 8'hFF);
    stray_en = 1'b0;

    runResetMid();
    applyStimulus(8'h01, 3, 1'b0, 8'h00);

    @(negedge clk);
    rst     = 1'b1;
    load    = 1'b1;
    data_in = 8'hAA;
    @(negedge clk);
    checkOutput("rst_load_timer_start", timer_start, 0);
    checkOutput("rst_load_busy", busy, 0);
    rst  = 1'b0;
    load = 1'b0;
    @(negedge clk);
    checkOutput("rst_load_timer_start_after", timer_start, 0);
    checkOutput("rst_load_busy_after", busy, 0);

    applyStimulus(8'h07, 2, 1'b0, 8'h00);

    for (int n = 0; n < 20; n++) begin
      logic [WIDTH-1:0] d;
      d        = WIDTH'($urandom);
      stray_en = ($urandom_range(1, 0) == 1);
      applyStimulus(d, $urandom_range(12, 1), ($urandom_range(1, 0) == 1), ~d);
    end
    stray_en = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("bits_left", bit_q.size(), 0);
    checkOutput("dones_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
